// File: rtl/pong_match_controller.sv
// Match sequencer for two-player Pong: walks idle/serve/play/point/over rounds,
// keeps both scores and gates the ball/paddle datapath. All outputs registered.
module pong_match_controller #(
   parameter int WIN_SCORE    = 9,
   parameter int SCORE_W      = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_frame_tick,
   input  logic               i_start,
   input  logic               i_miss_left,
   input  logic               i_miss_right,
   output logic               o_play_enable,
   output logic               o_ball_reset,
   output logic               o_serve_dir,
   output logic [SCORE_W-1:0] o_p1_score,
   output logic [SCORE_W-1:0] o_p2_score,
   output logic               o_point_pulse,
   output logic               o_game_over,
   output logic               o_winner,
   output logic [2:0]         o_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SERVE = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_POINT = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;

   localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
   // The tick that brings the count up to N is the one seen while the count is N-1.
   localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

   logic [2:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [SCORE_W-1:0] r_p1;
   logic [SCORE_W-1:0] r_p2;
   logic               r_serve_dir;
   logic               r_winner;
   logic               r_point;
   logic               r_start_q;
   logic               r_play_enable;
   logic               r_ball_reset;
   logic               r_game_over;

   logic [2:0]         w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [SCORE_W-1:0] w_p1_nxt;
   logic [SCORE_W-1:0] w_p2_nxt;
   logic [SCORE_W-1:0] w_p1_inc;
   logic [SCORE_W-1:0] w_p2_inc;
   logic               w_dir_nxt;
   logic               w_winner_nxt;
   logic               w_point_nxt;
   logic               w_start_rise;

   assign w_start_rise = i_start & ~r_start_q;
   assign w_p1_inc     = r_p1 + SCORE_W'(1);
   assign w_p2_inc     = r_p2 + SCORE_W'(1);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_p1_nxt     = r_p1;
      w_p2_nxt     = r_p2;
      w_dir_nxt    = r_serve_dir;
      w_winner_nxt = r_winner;
      w_point_nxt  = 1'b0;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (w_start_rise) begin
               w_p1_nxt    = '0;
               w_p2_nxt    = '0;
               w_dir_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SERVE;
            end
         end
         S_SERVE: begin
            if (i_frame_tick) begin
               if (r_cnt == SERVE_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_PLAY;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         S_PLAY: begin
            // A double miss in one cycle is treated as no point at all.
            if (i_miss_left ^ i_miss_right) begin
               w_point_nxt = 1'b1;
               w_cnt_nxt   = '0;
               if (i_miss_left) begin
                  w_p2_nxt  = w_p2_inc;
                  w_dir_nxt = 1'b0;
                  if (w_p2_inc == WIN) begin
                     w_winner_nxt = 1'b1;
                     w_state_nxt  = S_OVER;
                  end else begin
                     w_state_nxt = S_POINT;
                  end
               end else begin
                  w_p1_nxt  = w_p1_inc;
                  w_dir_nxt = 1'b1;
                  if (w_p1_inc == WIN) begin
                     w_winner_nxt = 1'b0;
                     w_state_nxt  = S_OVER;
                  end else begin
                     w_state_nxt = S_POINT;
                  end
               end
            end
         end
         S_POINT: begin
            if (i_frame_tick) begin
               if (r_cnt == POINT_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_SERVE;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_p1          <= '0;
         r_p2          <= '0;
         r_serve_dir   <= 1'b1;
         r_winner      <= 1'b0;
         r_point       <= 1'b0;
         r_start_q     <= 1'b1;
         r_play_enable <= 1'b0;
         r_ball_reset  <= 1'b1;
         r_game_over   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_p1          <= w_p1_nxt;
         r_p2          <= w_p2_nxt;
         r_serve_dir   <= w_dir_nxt;
         r_winner      <= w_winner_nxt;
         r_point       <= w_point_nxt;
         r_start_q     <= i_start;
         r_play_enable <= (w_state_nxt == S_PLAY);
         // In POINT the ball stays frozen where it left the field, not re-centred.
         r_ball_reset  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_SERVE) ||
                          (w_state_nxt == S_OVER);
         r_game_over   <= (w_state_nxt == S_OVER);
      end
   end

   assign o_state       = r_state;
   assign o_play_enable = r_play_enable;
   assign o_ball_reset  = r_ball_reset;
   assign o_serve_dir   = r_serve_dir;
   assign o_p1_score    = r_p1;
   assign o_p2_score    = r_p2;
   assign o_point_pulse = r_point;
   assign o_game_over   = r_game_over;
   assign o_winner      = r_winner;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: scenario tasks push expected output vectors
// into a queue as they drive each cycle, then pop and compare after the edge.
module tb_pong_match_controller;

   localparam int SW  = 4;
   localparam int WIN = 6;
   localparam int SF  = 3;
   localparam int PF  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tick = 1'b0;
   logic          start = 1'b0;
   logic          ml = 1'b0;
   logic          mr = 1'b0;
   logic          play_enable, ball_reset, serve_dir, point_pulse, game_over, winner;
   logic [SW-1:0] p1_score, p2_score;
   logic [2:0]    state;

   pong_match_controller #(
      .WIN_SCORE(WIN), .SCORE_W(SW), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
   ) dut (
      .i_clock(clk), .i_reset(rst), .i_frame_tick(tick), .i_start(start),
      .i_miss_left(ml), .i_miss_right(mr),
      .o_play_enable(play_enable), .o_ball_reset(ball_reset), .o_serve_dir(serve_dir),
      .o_p1_score(p1_score), .o_p2_score(p2_score), .o_point_pulse(point_pulse),
      .o_game_over(game_over), .o_winner(winner), .o_state(state)
   );

   always #5 clk = ~clk;

   // {state, play_enable, ball_reset, serve_dir, p1, p2, point_pulse, game_over, winner}
   logic [16:0] obs;
   assign obs = {state, play_enable, ball_reset, serve_dir, p1_score, p2_score,
                 point_pulse, game_over, winner};

   logic [16:0] exp_q[$];
   logic [16:0] e;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [SW-1:0] m_p1 = '0;
   logic [SW-1:0] m_p2 = '0;
   logic          m_sd = 1'b1;
   logic          m_w = 1'b0;

   // Gating outputs follow directly from the state the controller is in.
   function automatic logic [16:0] ev(input logic [2:0] st, input logic pp);
      logic pe, br, go;
      pe = (st == 3'd2);
      br = (st == 3'd0) || (st == 3'd1) || (st == 3'd4);
      go = (st == 3'd4);
      return {st, pe, br, m_sd, m_p1, m_p2, pp, go, m_w};
   endfunction

   task automatic cycle(input logic t, input logic s, input logic l, input logic r);
      tick = t; start = s; ml = l; mr = r;
      @(posedge clk);
      #1;
      tick = 1'b0; ml = 1'b0; mr = 1'b0;
   endtask

   task automatic drive_frames(input int n, input logic [2:0] st_during,
                               input logic [2:0] st_after, input string name);
      for (int i = 1; i <= n; i++) begin
         exp_q.push_back(ev((i == n) ? st_after : st_during, 1'b0));
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL %s tick %0d: got %h expected %h", name, i, obs, e);
         end
      end
   endtask

   task automatic score(input logic l, input logic t, input bit finish_round);
      if (l) begin m_p2 = m_p2 + 1'b1; m_sd = 1'b0; end
      else   begin m_p1 = m_p1 + 1'b1; m_sd = 1'b1; end
      if (m_p1 == WIN || m_p2 == WIN) begin
         m_w = l;
         exp_q.push_back(ev(3'd4, 1'b1));
      end else begin
         exp_q.push_back(ev(3'd3, 1'b1));
      end
      cycle(t, 1'b0, l, ~l);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL point_scored p1=%0d p2=%0d: got %h expected %h", m_p1, m_p2, obs, e);
      end
      if (finish_round && state != 3'd4) begin
         drive_frames(PF, 3'd3, 3'd1, "point_pause");
         drive_frames(SF, 3'd1, 3'd2, "serve_after_point");
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(ev(3'd0, 1'b0));
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL reset_values: got %h expected %h", obs, e);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         // Three cycles with start still held, then one with it dropped.
         exp_q.push_back(ev(3'd0, 1'b0));
         cycle(1'b0, (i < 3), 1'b0, 1'b0);
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL start_held_through_reset cycle %0d: got %h expected %h", i, obs, e);
         end
      end
      exp_q.push_back(ev(3'd1, 1'b0));
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL start_rise: got %h expected %h", obs, e);
      end
   endtask

   task automatic test_serve;
      for (int i = 1; i <= SF; i++) begin
         // Idle cycle between ticks; the first carries a miss that SERVE must ignore.
         exp_q.push_back(ev(3'd1, 1'b0));
         cycle(1'b0, 1'b0, (i == 1), (i == 2));
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL serve_hold %0d: got %h expected %h", i, obs, e);
         end
         exp_q.push_back(ev((i == SF) ? 3'd2 : 3'd1, 1'b0));
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL serve_tick %0d: got %h expected %h", i, obs, e);
         end
      end
   endtask

   task automatic test_point;
      exp_q.push_back(ev(3'd2, 1'b0));
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL play_tick: got %h expected %h", obs, e);
      end
      score(1'b1, 1'b0, 1'b0);
      // Pulse must drop, and a miss during POINT must not score.
      exp_q.push_back(ev(3'd3, 1'b0));
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL point_miss_ignored: got %h expected %h", obs, e);
      end
      drive_frames(PF, 3'd3, 3'd1, "point_to_serve");
      drive_frames(SF, 3'd1, 3'd2, "serve_to_play");
   endtask

   task automatic test_simultaneous;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(ev(3'd2, 1'b0));
         cycle(i[0], 1'b0, 1'b1, 1'b1);
         e = exp_q.pop_front();
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL double_miss %0d: got %h expected %h", i, obs, e);
         end
      end
   endtask

   task automatic test_mid_point_reset;
      // Miss coincident with a tick: the pause must still last the full PF ticks.
      score(1'b0, 1'b1, 1'b1);
      score(1'b0, 1'b0, 1'b1);
      score(1'b0, 1'b0, 1'b1);
      score(1'b1, 1'b0, 1'b1);
      score(1'b1, 1'b0, 1'b1);
      score(1'b1, 1'b0, 1'b1);
      score(1'b1, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      m_p1 = '0; m_p2 = '0; m_sd = 1'b1; m_w = 1'b0;
      exp_q.push_back(ev(3'd0, 1'b0));
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL async_reset_mid_point: got %h expected %h", obs, e);
      end
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(ev(3'd1, 1'b0));
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
         n_fail++;
         $display("FAIL restart_after_reset: got %h expected %h", obs, e);
      end
      drive_frames(SF, 3'd1, 3'd2, "serve_after_reset");
   endtask

   task automatic test_game_over;
      for (int g = 0; g < 2; g++) begin
         // First game P1 wins via right misses, second P2 wins via left misses.
         for (int k = 0; k < WIN; k++) score(g[0], 1'b0, 1'b1);
         for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ev(3'd4, 1'b0));
            cycle(i[0], 1'b0, 1'b1, i[0]);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
               n_fail++;
               $display("FAIL over_hold game %0d cycle %0d: got %h expected %h", g, i, obs, e);
            end
         end
         if (g == 0) begin
            m_p1 = '0; m_p2 = '0; m_sd = 1'b1;
            exp_q.push_back(ev(3'd1, 1'b0));
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
               n_fail++;
               $display("FAIL restart_from_over: got %h expected %h", obs, e);
            end
            drive_frames(SF, 3'd1, 3'd2, "serve_new_game");
         end
      end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_point();
      test_simultaneous();
      test_mid_point_reset();
      test_game_over();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
